// File: rtl/mem_arbiter_if.sv
// Requester, memory and stall signals shared between the arbiter and its neighbours.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32
) ();

  // Instruction-fetch requester
  logic              i_f_req;
  logic [ADDR_W-1:0] i_f_addr;
  logic              o_f_rvalid;
  logic [31:0]       o_f_rdata;
  logic              o_f_err;

  // Load/store requester
  logic              i_d_req;
  logic              i_d_we;
  logic [ADDR_W-1:0] i_d_addr;
  logic [31:0]       i_d_wdata;
  logic [3:0]        i_d_strb;
  logic              o_d_rvalid;
  logic [31:0]       o_d_rdata;
  logic              o_d_err;

  // Single-ported memory bus
  logic              o_mem_req;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [31:0]       o_mem_wdata;
  logic [3:0]        o_mem_strb;
  logic              i_mem_ack;
  logic [31:0]       i_mem_rdata;

  // Core PC-enable stall
  logic              o_stall;

  // Arbiter side
  modport slave (
    input  i_f_req, i_f_addr,
    input  i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_strb,
    input  i_mem_ack, i_mem_rdata,
    output o_f_rvalid, o_f_rdata, o_f_err,
    output o_d_rvalid, o_d_rdata, o_d_err,
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_strb,
    output o_stall
  );

  // Requester / memory side
  modport master (
    output i_f_req, i_f_addr,
    output i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_strb,
    output i_mem_ack, i_mem_rdata,
    input  o_f_rvalid, o_f_rdata, o_f_err,
    input  o_d_rvalid, o_d_rdata, o_d_err,
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_strb,
    input  o_stall
  );

endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter and sequencer for one single-ported
// memory, with round-robin tie break, access timeout and core stall.
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  mem_arbiter_if.slave bus
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned CNT_W  = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
  localparam logic TO_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic {
    GNT_FETCH = 1'b0,
    GNT_DATA  = 1'b1
  } gnt_t;

  state_t             state_q;
  gnt_t               last_gnt_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               mem_req_q;
  logic               mem_we_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [DATA_W-1:0]  mem_wdata_q;
  logic [STRB_W-1:0]  mem_strb_q;

  logic               f_rvalid_q;
  logic [DATA_W-1:0]  f_rdata_q;
  logic               f_err_q;
  logic               d_rvalid_q;
  logic [DATA_W-1:0]  d_rdata_q;
  logic               d_err_q;

  logic               pick_fetch_c;
  logic               timeout_c;

  // Round-robin pick: fetch wins unless data is also pending and fetch went last.
  always_comb begin
    pick_fetch_c = bus.i_f_req & (~bus.i_d_req | (last_gnt_q == GNT_DATA));
  end

  // Abort once the access has spent TIMEOUT cycles in BUSY.
  always_comb begin
    timeout_c = TO_EN & (cnt_q == CNT_LAST);
  end

  // Arbiter FSM with registered memory command and responses.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      last_gnt_q  <= GNT_DATA;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_strb_q  <= '0;
      f_rvalid_q  <= 1'b0;
      f_rdata_q   <= '0;
      f_err_q     <= 1'b0;
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= '0;
      d_err_q     <= 1'b0;
    end else begin
      f_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (bus.i_f_req | bus.i_d_req) begin
            cnt_q     <= '0;
            mem_req_q <= 1'b1;
            state_q   <= ST_BUSY;
            if (pick_fetch_c) begin
              last_gnt_q  <= GNT_FETCH;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= bus.i_f_addr;
              mem_wdata_q <= '0;
              mem_strb_q  <= '0;
            end else begin
              last_gnt_q  <= GNT_DATA;
              mem_we_q    <= bus.i_d_we;
              mem_addr_q  <= bus.i_d_addr;
              mem_wdata_q <= bus.i_d_wdata;
              mem_strb_q  <= bus.i_d_strb;
            end
          end
        end

        ST_BUSY: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (bus.i_mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= ST_RESP;
            if (last_gnt_q == GNT_FETCH) begin
              f_rvalid_q <= 1'b1;
              f_rdata_q  <= bus.i_mem_rdata;
              f_err_q    <= 1'b0;
            end else begin
              d_rvalid_q <= 1'b1;
              d_rdata_q  <= mem_we_q ? '0 : bus.i_mem_rdata;
              d_err_q    <= 1'b0;
            end
          end else if (timeout_c) begin
            mem_req_q <= 1'b0;
            state_q   <= ST_RESP;
            if (last_gnt_q == GNT_FETCH) begin
              f_rvalid_q <= 1'b1;
              f_rdata_q  <= '0;
              f_err_q    <= 1'b1;
            end else begin
              d_rvalid_q <= 1'b1;
              d_rdata_q  <= '0;
              d_err_q    <= 1'b1;
            end
          end
        end

        ST_RESP: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q   <= ST_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_mem_req   = mem_req_q;
  assign bus.o_mem_we    = mem_we_q;
  assign bus.o_mem_addr  = mem_addr_q;
  assign bus.o_mem_wdata = mem_wdata_q;
  assign bus.o_mem_strb  = mem_strb_q;

  assign bus.o_f_rvalid  = f_rvalid_q;
  assign bus.o_f_rdata   = f_rdata_q;
  assign bus.o_f_err     = f_err_q;
  assign bus.o_d_rvalid  = d_rvalid_q;
  assign bus.o_d_rdata   = d_rdata_q;
  assign bus.o_d_err     = d_err_q;

  // Hold the PC while any requester is still waiting; drops in the response cycle.
  assign bus.o_stall = (bus.i_f_req & ~f_rvalid_q) | (bus.i_d_req & ~d_rvalid_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, hand-written corner sequences and a
// randomized phase scored against a transaction-level memory/requester model.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int          TO     = 4;
  localparam int          ISSUE_CYCLES = 2500;
  localparam int          RUN_LIMIT    = 2700;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TO)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit          is_data;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          ack_at;     // BUSY cycle carrying the ack, 0 = never
    logic [31:0] mdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_len;    // cycles o_mem_req stays high
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    bit          err;
  } resp_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_f_req     = 1'b0;
    bus.i_f_addr    = '0;
    bus.i_d_req     = 1'b0;
    bus.i_d_we      = 1'b0;
    bus.i_d_addr    = '0;
    bus.i_d_wdata   = '0;
    bus.i_d_strb    = '0;
    bus.i_mem_ack   = 1'b0;
    bus.i_mem_rdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".mem_req"},   32'(bus.o_mem_req),  32'h0);
    chk({tag, ".mem_we"},    32'(bus.o_mem_we),   32'h0);
    chk({tag, ".mem_addr"},  bus.o_mem_addr,      32'h0);
    chk({tag, ".mem_wdata"}, bus.o_mem_wdata,     32'h0);
    chk({tag, ".mem_strb"},  32'(bus.o_mem_strb), 32'h0);
    chk({tag, ".f_rvalid"},  32'(bus.o_f_rvalid), 32'h0);
    chk({tag, ".f_rdata"},   bus.o_f_rdata,       32'h0);
    chk({tag, ".f_err"},     32'(bus.o_f_err),    32'h0);
    chk({tag, ".d_rvalid"},  32'(bus.o_d_rvalid), 32'h0);
    chk({tag, ".d_rdata"},   bus.o_d_rdata,       32'h0);
    chk({tag, ".d_err"},     32'(bus.o_d_err),    32'h0);
    chk({tag, ".stall"},     32'(bus.o_stall),    32'h0);
  endtask

  // One isolated access from IDLE, then a stray ack in the following idle cycle.
  task automatic apply_vec(input int idx, input vec_t v);
    int    cyc;
    int    len;
    bit    got;
    string nm;
    nm  = $sformatf("vec%0d", idx);
    cyc = 0;
    len = 0;
    got = 1'b0;
    if (v.is_data) begin
      bus.i_d_req   = 1'b1;
      bus.i_d_we    = v.we;
      bus.i_d_addr  = v.addr;
      bus.i_d_wdata = v.wdata;
      bus.i_d_strb  = v.strb;
    end else begin
      bus.i_f_req  = 1'b1;
      bus.i_f_addr = v.addr;
    end
    while (!got && cyc < 20) begin
      bus.i_mem_ack   = 1'b0;
      bus.i_mem_rdata = $urandom;
      if (bus.o_mem_req) begin
        len++;
        chk({nm, ".mem_addr"}, bus.o_mem_addr, v.addr);
        chk({nm, ".mem_we"},   32'(bus.o_mem_we), 32'(v.is_data ? v.we : 1'b0));
        chk({nm, ".mem_strb"}, 32'(bus.o_mem_strb), 32'(v.is_data ? v.strb : 4'h0));
        if (v.is_data && v.we) chk({nm, ".mem_wdata"}, bus.o_mem_wdata, v.wdata);
        if (len == v.ack_at) begin
          bus.i_mem_ack   = 1'b1;
          bus.i_mem_rdata = v.mdata;
        end
      end
      if (v.is_data ? bus.o_d_rvalid : bus.o_f_rvalid) begin
        got         = 1'b1;
        bus.i_f_req = 1'b0;
        bus.i_d_req = 1'b0;
        chk({nm, ".rdata"},   v.is_data ? bus.o_d_rdata : bus.o_f_rdata, v.exp_rdata);
        chk({nm, ".err"},     32'(v.is_data ? bus.o_d_err : bus.o_f_err), 32'(v.exp_err));
        chk({nm, ".req_len"}, 32'(len), 32'(v.exp_len));
        chk({nm, ".latency"}, 32'(cyc), 32'(v.exp_len + 1));
        chk({nm, ".other_rvalid"}, 32'(v.is_data ? bus.o_f_rvalid : bus.o_d_rvalid), 32'h0);
      end
      @(negedge clk);
      chk({nm, ".stall"}, 32'(bus.o_stall), 32'(!got));
      next_cycle();
      cyc++;
    end
    if (!got) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s.rvalid: got no response, required one within 20 cycles", nm);
      bus.i_f_req = 1'b0;
      bus.i_d_req = 1'b0;
    end
    bus.i_mem_ack   = 1'b1;
    bus.i_mem_rdata = 32'hBAD0_BAD0;
    chk({nm, ".rvalid_after"}, 32'(bus.o_f_rvalid | bus.o_d_rvalid), 32'h0);
    chk({nm, ".rdata_held"}, v.is_data ? bus.o_d_rdata : bus.o_f_rdata, v.exp_rdata);
    chk({nm, ".err_held"},   32'(v.is_data ? bus.o_d_err : bus.o_f_err), 32'(v.exp_err));
    next_cycle();
    bus.i_mem_ack = 1'b0;
    chk({nm, ".stray_mem_req"}, 32'(bus.o_mem_req), 32'h0);
    chk({nm, ".stray_rvalid"},  32'(bus.o_f_rvalid | bus.o_d_rvalid), 32'h0);
  endtask

  // Both requesters raised in the first cycle after reset, memory acks at once.
  task automatic contention_seq();
    bus.i_f_req  = 1'b1;
    bus.i_f_addr = 32'h0000_0100;
    bus.i_d_req  = 1'b1;
    bus.i_d_we   = 1'b0;
    bus.i_d_addr = 32'h8000_0200;
    for (int cyc = 0; cyc < 8; cyc++) begin
      bus.i_mem_ack   = bus.o_mem_req;
      bus.i_mem_rdata = bus.o_mem_addr ^ 32'h5A5A_0000;
      chk($sformatf("cont.mem_req%0d", cyc), 32'(bus.o_mem_req), 32'(cyc == 1 || cyc == 4));
      if (cyc == 1) chk("cont.first_addr",  bus.o_mem_addr, 32'h0000_0100);
      if (cyc == 4) chk("cont.second_addr", bus.o_mem_addr, 32'h8000_0200);
      chk($sformatf("cont.f_rvalid%0d", cyc), 32'(bus.o_f_rvalid), 32'(cyc == 2));
      chk($sformatf("cont.d_rvalid%0d", cyc), 32'(bus.o_d_rvalid), 32'(cyc == 5));
      if (bus.o_f_rvalid) begin
        bus.i_f_req = 1'b0;
        chk("cont.f_rdata", bus.o_f_rdata, 32'h5A5A_0100);
      end
      if (bus.o_d_rvalid) begin
        bus.i_d_req = 1'b0;
        chk("cont.d_rdata", bus.o_d_rdata, 32'hDA5A_0200);
      end
      @(negedge clk);
      chk($sformatf("cont.stall%0d", cyc), 32'(bus.o_stall), 32'(cyc < 5));
      next_cycle();
    end
    idle_inputs();
  endtask

  // Reset pulse while BUSY, then a late ack from the aborted access.
  task automatic reset_mid_seq();
    bus.i_f_req  = 1'b1;
    bus.i_f_addr = 32'h0000_0300;
    next_cycle();
    chk("rstmid.busy1", 32'(bus.o_mem_req), 32'h1);
    next_cycle();
    chk("rstmid.busy2", 32'(bus.o_mem_req), 32'h1);
    rst_n       = 1'b0;
    bus.i_f_req = 1'b0;
    next_cycle();
    check_reset_outputs("rstmid");
    rst_n           = 1'b1;
    bus.i_mem_ack   = 1'b1;
    bus.i_mem_rdata = 32'h1111_2222;
    next_cycle();
    bus.i_mem_ack = 1'b0;
    chk("rstmid.late_rvalid",  32'(bus.o_f_rvalid | bus.o_d_rvalid), 32'h0);
    chk("rstmid.late_mem_req", 32'(bus.o_mem_req), 32'h0);
  endtask

  // Randomized traffic against a transaction-level memory and requester model.
  task automatic random_phase();
    resp_t       f_exp[$];
    resp_t       d_exp[$];
    resp_t       e;
    int          f_gap, d_gap, f_issued, d_issued, f_done, d_done;
    int          age, ack_at, req_len, cyc;
    logic [31:0] ack_data, a;
    bit          prev_mreq, prev_f, prev_d, last_data, is_d, issuing;
    bit          c_we;
    logic [31:0] c_addr, c_wdata;
    logic [3:0]  c_strb;
    f_gap = 0; d_gap = 0; f_issued = 0; d_issued = 0; f_done = 0; d_done = 0;
    age = 0; ack_at = 1; req_len = 0; ack_data = '0;
    prev_mreq = 1'b0; prev_f = 1'b0; prev_d = 1'b0; last_data = 1'b1; is_d = 1'b0;
    c_we = 1'b0; c_addr = '0; c_wdata = '0; c_strb = '0;
    for (cyc = 0; cyc < RUN_LIMIT; cyc++) begin
      issuing = (cyc < ISSUE_CYCLES);
      // Responses and requester behaviour
      if (bus.o_f_rvalid) begin
        if (f_exp.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL rnd.f_unexpected: got o_f_rvalid=1 required 0 (nothing outstanding)");
        end else begin
          e = f_exp.pop_front();
          chk("rnd.f_rdata", bus.o_f_rdata, e.rdata);
          chk("rnd.f_err",   32'(bus.o_f_err), 32'(e.err));
        end
        bus.i_f_req = 1'b0;
        f_gap = $urandom_range(0, 3);
        f_done++;
      end else if (!bus.i_f_req) begin
        if (f_gap > 0) f_gap--;
        else if (issuing) begin
          a = $urandom; a[31] = 1'b0; a[1:0] = 2'b00;
          bus.i_f_req  = 1'b1;
          bus.i_f_addr = a;
          f_issued++;
        end
      end
      if (bus.o_d_rvalid) begin
        if (d_exp.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL rnd.d_unexpected: got o_d_rvalid=1 required 0 (nothing outstanding)");
        end else begin
          e = d_exp.pop_front();
          chk("rnd.d_rdata", bus.o_d_rdata, e.rdata);
          chk("rnd.d_err",   32'(bus.o_d_err), 32'(e.err));
        end
        bus.i_d_req = 1'b0;
        d_gap = $urandom_range(0, 3);
        d_done++;
      end else if (!bus.i_d_req) begin
        if (d_gap > 0) d_gap--;
        else if (issuing) begin
          a = $urandom; a[31] = 1'b1;
          bus.i_d_req   = 1'b1;
          bus.i_d_we    = 1'($urandom_range(0, 1));
          bus.i_d_addr  = a;
          bus.i_d_wdata = $urandom;
          bus.i_d_strb  = 4'($urandom_range(0, 15));
          d_issued++;
        end
      end
      // Memory model
      bus.i_mem_ack   = 1'b0;
      bus.i_mem_rdata = $urandom;
      if (bus.o_mem_req && !prev_mreq) begin
        age     = 1;
        req_len = 0;
        is_d    = bus.o_mem_addr[31];
        chk("rnd.grant_pending", 32'(is_d ? prev_d : prev_f), 32'h1);
        if (prev_f && prev_d) chk("rnd.round_robin", 32'(is_d), 32'(!last_data));
        last_data = is_d;
        if (is_d) begin
          chk("rnd.d_addr", bus.o_mem_addr, bus.i_d_addr);
          chk("rnd.d_we",   32'(bus.o_mem_we), 32'(bus.i_d_we));
          chk("rnd.d_strb", 32'(bus.o_mem_strb), 32'(bus.i_d_strb));
          if (bus.i_d_we) chk("rnd.d_wdata", bus.o_mem_wdata, bus.i_d_wdata);
        end else begin
          chk("rnd.f_addr", bus.o_mem_addr, bus.i_f_addr);
          chk("rnd.f_we",   32'(bus.o_mem_we), 32'h0);
          chk("rnd.f_strb", 32'(bus.o_mem_strb), 32'h0);
        end
        c_we = bus.o_mem_we; c_addr = bus.o_mem_addr;
        c_wdata = bus.o_mem_wdata; c_strb = bus.o_mem_strb;
        ack_at   = $urandom_range(1, 6);
        ack_data = $urandom;
        if (ack_at <= TO) begin
          e.rdata = (is_d && c_we) ? 32'h0 : ack_data;
          e.err   = 1'b0;
        end else begin
          e.rdata = 32'h0;
          e.err   = 1'b1;
        end
        if (is_d) d_exp.push_back(e);
        else      f_exp.push_back(e);
      end else if (age != 0) begin
        age++;
        if (age > 6) age = 0;
      end
      if (age != 0 && age == ack_at) begin
        bus.i_mem_ack   = 1'b1;
        bus.i_mem_rdata = ack_data;
      end
      if (bus.o_mem_req) begin
        req_len++;
        if (prev_mreq) begin
          chk("rnd.hold_addr",  bus.o_mem_addr, c_addr);
          chk("rnd.hold_we",    32'(bus.o_mem_we), 32'(c_we));
          chk("rnd.hold_wdata", bus.o_mem_wdata, c_wdata);
          chk("rnd.hold_strb",  32'(bus.o_mem_strb), 32'(c_strb));
        end
      end
      if (!bus.o_mem_req && prev_mreq)
        chk("rnd.req_len", 32'(req_len), 32'((ack_at <= TO) ? ack_at : TO));
      prev_mreq = bus.o_mem_req;
      prev_f    = bus.i_f_req;
      prev_d    = bus.i_d_req;
      @(negedge clk);
      chk("rnd.stall", 32'(bus.o_stall), 32'(bus.i_f_req | bus.i_d_req));
      next_cycle();
      if (!issuing && !bus.i_f_req && !bus.i_d_req && !bus.o_mem_req &&
          !bus.o_f_rvalid && !bus.o_d_rvalid) break;
    end
    chk("rnd.drained",   32'(bus.i_f_req | bus.i_d_req), 32'h0);
    chk("rnd.f_count",   32'(f_done), 32'(f_issued));
    chk("rnd.d_count",   32'(d_done), 32'(d_issued));
    chk("rnd.f_pending", 32'(f_exp.size()), 32'h0);
    chk("rnd.d_pending", 32'(d_exp.size()), 32'h0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         4'h0, 1, 32'h0000_0013, 32'h0000_0013, 1'b0, 1};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_7000, 32'hDEAD_BEEF, 4'hF, 3, 32'h0000_55AA, 32'h0,         1'b0, 3};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_7000, 32'h0,         4'h0, 2, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 2};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0020, 32'h0,         4'h0, 0, 32'h0,         32'h0,         1'b1, 4};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_8004, 32'h0,         4'h0, 4, 32'h1234_5678, 32'h1234_5678, 1'b0, 4};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_9001, 32'h0BAD_F00D, 4'h3, 0, 32'h0,         32'h0,         1'b1, 4};
    vecs[6] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 4, 32'h0000_A5A5, 32'h0000_A5A5, 1'b0, 4};

    idle_inputs();
    do_reset();
    check_reset_outputs("reset");
    contention_seq();
    for (int i = 0; i < 7; i++) apply_vec(i, vecs[i]);
    reset_mid_seq();
    apply_vec(7, vecs[0]);
    do_reset();
    random_phase();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer that shares one single-ported memory between the core's instruction-fetch path and its load/store path.
- It serializes the two requesters onto a req/ack memory bus and returns registered responses to each.
- It raises a stall that drives the core's PC enable low until every pending access has completed.
- It provides an access timeout with an error response, so a missing memory ack cannot hang the core.

Parameters:
- ADDR_W, 32, width of the byte address on both requester ports and the memory port.
- TIMEOUT, 16, number of BUSY cycles without an ack before the access is aborted. 0 disables the timeout.

Ports:
- i_clk  in  1  global clock, rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_f_req  in  1  fetch request; held high until o_f_rvalid.
- i_f_addr  in  ADDR_W  fetch address; stable while i_f_req is high.
- o_f_rvalid  out  1  one-cycle fetch completion pulse.
- o_f_rdata  out  32  fetched instruction; valid with o_f_rvalid.
- o_f_err  out  1  fetch timed out; valid with o_f_rvalid.
- i_d_req  in  1  data request; held high until o_d_rvalid.
- i_d_we  in  1  1 = store, 0 = load.
- i_d_addr  in  ADDR_W  data address.
- i_d_wdata  in  32  store data.
- i_d_strb  in  4  store byte strobes.
- o_d_rvalid  out  1  one-cycle data completion pulse.
- o_d_rdata  out  32  load data; 0 for stores and on error.
- o_d_err  out  1  data access timed out.
- o_mem_req  out  1  memory request; held until ack.
- o_mem_we, o_mem_addr, o_mem_wdata, o_mem_strb  out  1/ADDR_W/32/4  registered memory command.
- i_mem_ack  in  1  memory completion; one cycle.
- i_mem_rdata  in  32  read data; valid with i_mem_ack.
- o_stall  out  1  core stall; drives PC enable low.

Behaviour:
- Clock is i_clk. Reset i_rst_n is synchronous and active-low.
- Reset values:
  - state = IDLE, last_gnt = DATA, timeout counter = 0.
  - All o_* registers = 0, including o_mem_req and the memory command.
- Three-state FSM: IDLE, BUSY, RESP.
- IDLE:
  - No request pending: stay in IDLE.
  - One request pending: grant it.
  - Both pending: grant the requester not equal to last_gnt (round-robin). Fetch therefore wins the first tie after reset.
  - On grant: register the command onto o_mem_*, set last_gnt, clear the counter, and go to BUSY.
  - A fetch grant forces o_mem_we = 0 and o_mem_strb = 0.
- BUSY:
  - o_mem_req = 1 and the command is held stable.
  - The counter increments each cycle.
  - i_mem_ack = 1: capture i_mem_rdata (forced to 0 for stores) into the granted requester's rdata, set err = 0, go to RESP.
  - Else, if TIMEOUT != 0 and the counter equals TIMEOUT-1: set rdata = 0, err = 1, go to RESP.
  - Ack and timeout in the same cycle: ack wins, err = 0.
- RESP:
  - o_mem_req = 0.
  - The granted requester's rvalid = 1 for exactly this cycle.
  - Next state is always IDLE. The requester drops req in this cycle, and no new grant is issued in RESP.
- Latency: request seen at cycle N gives o_mem_req at N+1. An ack at cycle M (M >= N+1) gives rvalid at M+1. Minimum is 3 cycles per access with 1 idle cycle between accesses.
- Response data:
  - rdata and err are held after the rvalid pulse until the next response to the same requester.
  - rvalid is low outside RESP.
- Stall: o_stall = (i_f_req & ~o_f_rvalid) | (i_d_req & ~o_d_rvalid). This is combinational and goes low in the response cycle.
- Width rules:
  - Counter width is $clog2(TIMEOUT+1), minimum 1 bit.
  - The address is passed through unmodified, with no alignment checks.
- Stray acks: i_mem_ack in IDLE or RESP is ignored.
- Withdrawn request: a req that drops before rvalid is a protocol violation. The access still completes, and rvalid still pulses.
- Reset mid-access: the next edge returns to IDLE and clears o_mem_req; no rvalid is issued. A later ack from the aborted access is ignored.

Test Plan:
- Single fetch:
  - Stimulus: i_f_req = 1, addr = 0x0000_0010 at cycle 0; ack at cycle 1 with rdata = 0x0000_0013.
  - Required: o_mem_req high in cycle 1 with o_mem_we = 0; o_f_rvalid = 1 in cycle 2 with o_f_rdata = 0x13 and err = 0; o_stall high in cycles 0-1 and low in cycle 2.
- Store with wait states:
  - Stimulus: i_d_req, we = 1, addr = 0x7000, wdata = 0xDEADBEEF, strb = 0xF; ack 3 cycles after o_mem_req rises.
  - Required: o_mem_* stable for all 3 cycles; o_d_rvalid one cycle after the ack; o_d_rdata = 0.
- Contention:
  - Stimulus: i_f_req and i_d_req both raised in the first cycle after reset; memory acks immediately.
  - Required: fetch granted first, data second (second o_mem_req 3 cycles after the first); o_stall stays high until o_d_rvalid.
- Timeout:
  - Stimulus: TIMEOUT = 4, no ack.
  - Required: o_mem_req high for 4 cycles; then rvalid = 1, err = 1, rdata = 0. A subsequent late ack in IDLE produces no rvalid.
- Ack on timeout edge:
  - Stimulus: TIMEOUT = 4, ack arrives in the 4th BUSY cycle.
  - Required: err = 0 and the acked rdata is returned.
- Reset mid-access:
  - Stimulus: i_rst_n = 0 for one cycle while BUSY, then an ack.
  - Required: o_mem_req = 0 after the reset edge; no rvalid; all outputs at reset values; a fresh request completes normally.
